// File: rtl/mips_pipe_defs.sv
// Shared definitions for the MIPS-style ID/EX stage: stall FSM states,
// default field widths and the bubble control word.
package mips_pipe_defs;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALUOP_W    = 4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_e;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
    } ex_ctrl_t;

    // A bubble must never write state, so every control bit is clear.
    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    function automatic logic [1:0] max_bubbles(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_classifier.sv
// Combinational hazard detector: number of bubbles (0..2) the instruction in ID
// needs before it may enter EX, given ID/EX and EX/MEM contents.
module hazard_classifier
    import mips_pipe_defs::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  if_id_valid,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    input  logic                  uses_rt,
    input  logic                  branch,
    input  logic                  id_ex_valid,
    input  logic                  id_ex_regwrite,
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_wreg,
    input  logic                  ex_mem_memread,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic [1:0]            bubble_count
);

    logic ex_match;
    logic mem_match;
    logic [1:0] load_n;
    logic [1:0] br_alu_n;
    logic [1:0] br_mem_n;

    // Register $0 is hard-wired, so it never creates a dependency.
    assign ex_match  = if_id_valid && (id_ex_wreg != '0) &&
                       ((if_id_rs == id_ex_wreg) || (uses_rt && (if_id_rt == id_ex_wreg)));
    assign mem_match = if_id_valid && (ex_mem_rd != '0) &&
                       ((if_id_rs == ex_mem_rd) || (uses_rt && (if_id_rt == ex_mem_rd)));

    always_comb begin
        load_n   = 2'd0;
        br_alu_n = 2'd0;
        br_mem_n = 2'd0;
        if (id_ex_valid && id_ex_memread && ex_match)
            load_n = branch ? 2'd2 : 2'd1;
        if (branch && id_ex_valid && id_ex_regwrite && !id_ex_memread && ex_match)
            br_alu_n = 2'd1;
        if (branch && ex_mem_memread && mem_match)
            br_mem_n = 2'd1;
        bubble_count = max_bubbles(load_n, max_bubbles(br_alu_n, br_mem_n));
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use / branch-in-ID stall control.
// Optional HAZARD_STATS_EN adds saturating STALL_CYCLES and FLUSH_COUNT outputs.
module id_ex_stage_reg
    import mips_pipe_defs::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  GLOBAL_STALL,
    input  logic                  FLUSH,
    input  logic                  IF_ID_VALID,
    input  logic [REG_ADDR_W-1:0] IF_ID_RS,
    input  logic [REG_ADDR_W-1:0] IF_ID_RT,
    input  logic [REG_ADDR_W-1:0] IF_ID_RD,
    input  logic                  ID_USES_RT,
    input  logic                  ID_BRANCH,
    input  logic                  ID_REGWRITE,
    input  logic                  ID_MEMREAD,
    input  logic                  ID_MEMWRITE,
    input  logic                  ID_MEMTOREG,
    input  logic                  ID_ALUSRC,
    input  logic                  ID_REGDST,
    input  logic [ALUOP_W-1:0]    ID_ALUOP,
    input  logic [DATA_W-1:0]     ID_RD1,
    input  logic [DATA_W-1:0]     ID_RD2,
    input  logic [DATA_W-1:0]     ID_IMM,
    input  logic                  EX_MEM_MEMREAD,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RD,
    output logic                  ID_EX_VALID,
    output logic                  ID_EX_REGWRITE,
    output logic                  ID_EX_MEMREAD,
    output logic                  ID_EX_MEMWRITE,
    output logic                  ID_EX_MEMTOREG,
    output logic                  ID_EX_ALUSRC,
    output logic [ALUOP_W-1:0]    ID_EX_ALUOP,
    output logic [REG_ADDR_W-1:0] ID_EX_RS,
    output logic [REG_ADDR_W-1:0] ID_EX_RT,
    output logic [REG_ADDR_W-1:0] ID_EX_WREG,
    output logic [DATA_W-1:0]     ID_EX_RD1,
    output logic [DATA_W-1:0]     ID_EX_RD2,
    output logic [DATA_W-1:0]     ID_EX_IMM,
    output logic                  PC_WRITE,
    output logic                  IF_ID_WRITE,
    output logic                  HAZ_STALL
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           STALL_CYCLES,
    output logic [31:0]           FLUSH_COUNT
`endif
);

    stall_state_e state;
    logic [1:0]   hold_cnt;
    logic [1:0]   haz_count;
    logic         bubble_now;

    hazard_classifier #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_classifier (
        .if_id_valid    (IF_ID_VALID),
        .if_id_rs       (IF_ID_RS),
        .if_id_rt       (IF_ID_RT),
        .uses_rt        (ID_USES_RT),
        .branch         (ID_BRANCH),
        .id_ex_valid    (ID_EX_VALID),
        .id_ex_regwrite (ID_EX_REGWRITE),
        .id_ex_memread  (ID_EX_MEMREAD),
        .id_ex_wreg     (ID_EX_WREG),
        .ex_mem_memread (EX_MEM_MEMREAD),
        .ex_mem_rd      (EX_MEM_RD),
        .bubble_count   (haz_count)
    );

    // HOLD always bubbles; RUN bubbles only when a hazard is seen this cycle.
    assign bubble_now  = (state == ST_HOLD) || (haz_count != 2'd0);
    assign HAZ_STALL   = !GLOBAL_STALL && !FLUSH && bubble_now;
    assign PC_WRITE    = !GLOBAL_STALL && (FLUSH || !bubble_now);
    assign IF_ID_WRITE = PC_WRITE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD,
             ID_EX_MEMWRITE, ID_EX_MEMTOREG, ID_EX_ALUSRC} <= BUBBLE_CTRL;
            ID_EX_ALUOP <= '0;
            ID_EX_RS    <= '0;
            ID_EX_RT    <= '0;
            ID_EX_WREG  <= '0;
            ID_EX_RD1   <= '0;
            ID_EX_RD2   <= '0;
            ID_EX_IMM   <= '0;
            state       <= ST_RUN;
            hold_cnt    <= 2'd0;
        end else if (!GLOBAL_STALL) begin
            if (FLUSH || bubble_now) begin
                {ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD,
                 ID_EX_MEMWRITE, ID_EX_MEMTOREG, ID_EX_ALUSRC} <= BUBBLE_CTRL;
                ID_EX_ALUOP <= '0;
                ID_EX_RS    <= '0;
                ID_EX_RT    <= '0;
                ID_EX_WREG  <= '0;
                ID_EX_RD1   <= '0;
                ID_EX_RD2   <= '0;
                ID_EX_IMM   <= '0;
                if (FLUSH) begin
                    state    <= ST_RUN;
                    hold_cnt <= 2'd0;
                end else if (state == ST_RUN) begin
                    if (haz_count == 2'd2) begin
                        state    <= ST_HOLD;
                        hold_cnt <= 2'd1;
                    end
                end else begin
                    hold_cnt <= hold_cnt - 2'd1;
                    if (hold_cnt <= 2'd1)
                        state <= ST_RUN;
                end
            end else begin
                ID_EX_VALID    <= IF_ID_VALID;
                ID_EX_REGWRITE <= ID_REGWRITE;
                ID_EX_MEMREAD  <= ID_MEMREAD;
                ID_EX_MEMWRITE <= ID_MEMWRITE;
                ID_EX_MEMTOREG <= ID_MEMTOREG;
                ID_EX_ALUSRC   <= ID_ALUSRC;
                ID_EX_ALUOP    <= ID_ALUOP;
                ID_EX_RS       <= IF_ID_RS;
                ID_EX_RT       <= IF_ID_RT;
                ID_EX_WREG     <= ID_REGDST ? IF_ID_RD : IF_ID_RT;
                ID_EX_RD1      <= ID_RD1;
                ID_EX_RD2      <= ID_RD2;
                ID_EX_IMM      <= ID_IMM;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            STALL_CYCLES <= '0;
            FLUSH_COUNT  <= '0;
        end else begin
            if (HAZ_STALL && (STALL_CYCLES != '1))
                STALL_CYCLES <= STALL_CYCLES + 32'd1;
            if (FLUSH && !GLOBAL_STALL && (FLUSH_COUNT != '1))
                FLUSH_COUNT <= FLUSH_COUNT + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed pipeline scenarios followed by random
// traffic, all checked every cycle against a bubble-count model.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          GLOBAL_STALL, FLUSH, IF_ID_VALID;
    logic [AW-1:0] IF_ID_RS, IF_ID_RT, IF_ID_RD;
    logic          ID_USES_RT, ID_BRANCH, ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE;
    logic          ID_MEMTOREG, ID_ALUSRC, ID_REGDST;
    logic [OW-1:0] ID_ALUOP;
    logic [DW-1:0] ID_RD1, ID_RD2, ID_IMM;
    logic          EX_MEM_MEMREAD;
    logic [AW-1:0] EX_MEM_RD;
    logic          ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE;
    logic          ID_EX_MEMTOREG, ID_EX_ALUSRC;
    logic [OW-1:0] ID_EX_ALUOP;
    logic [AW-1:0] ID_EX_RS, ID_EX_RT, ID_EX_WREG;
    logic [DW-1:0] ID_EX_RD1, ID_EX_RD2, ID_EX_IMM;
    logic          PC_WRITE, IF_ID_WRITE, HAZ_STALL;
`ifdef HAZARD_STATS_EN
    logic [31:0]   STALL_CYCLES, FLUSH_COUNT;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .GLOBAL_STALL(GLOBAL_STALL), .FLUSH(FLUSH),
        .IF_ID_VALID(IF_ID_VALID), .IF_ID_RS(IF_ID_RS), .IF_ID_RT(IF_ID_RT),
        .IF_ID_RD(IF_ID_RD), .ID_USES_RT(ID_USES_RT), .ID_BRANCH(ID_BRANCH),
        .ID_REGWRITE(ID_REGWRITE), .ID_MEMREAD(ID_MEMREAD), .ID_MEMWRITE(ID_MEMWRITE),
        .ID_MEMTOREG(ID_MEMTOREG), .ID_ALUSRC(ID_ALUSRC), .ID_REGDST(ID_REGDST),
        .ID_ALUOP(ID_ALUOP), .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_IMM(ID_IMM),
        .EX_MEM_MEMREAD(EX_MEM_MEMREAD), .EX_MEM_RD(EX_MEM_RD),
        .ID_EX_VALID(ID_EX_VALID), .ID_EX_REGWRITE(ID_EX_REGWRITE),
        .ID_EX_MEMREAD(ID_EX_MEMREAD), .ID_EX_MEMWRITE(ID_EX_MEMWRITE),
        .ID_EX_MEMTOREG(ID_EX_MEMTOREG), .ID_EX_ALUSRC(ID_EX_ALUSRC),
        .ID_EX_ALUOP(ID_EX_ALUOP), .ID_EX_RS(ID_EX_RS), .ID_EX_RT(ID_EX_RT),
        .ID_EX_WREG(ID_EX_WREG), .ID_EX_RD1(ID_EX_RD1), .ID_EX_RD2(ID_EX_RD2),
        .ID_EX_IMM(ID_EX_IMM), .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE),
        .HAZ_STALL(HAZ_STALL)
`ifdef HAZARD_STATS_EN
        , .STALL_CYCLES(STALL_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
`endif
    );

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic          uses_rt, branch, regwrite, memread, memwrite, memtoreg, alusrc, regdst;
        logic [OW-1:0] aluop;
        logic [DW-1:0] rd1, rd2, imm;
    } instr_t;

    typedef struct packed {
        logic          valid, regwrite, memread, memwrite, memtoreg, alusrc;
        logic [OW-1:0] aluop;
        logic [AW-1:0] rs, rt, wreg;
        logic [DW-1:0] rd1, rd2, imm;
    } stage_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- instruction builders and driver tasks ----------------
    function automatic instr_t nop_i();
        instr_t i = '0;
        return i;
    endfunction

    function automatic instr_t lw_i(input int rt, input int rs);
        instr_t i = '0;
        i.valid = 1'b1; i.rs = AW'(rs); i.rt = AW'(rt);
        i.regwrite = 1'b1; i.memread = 1'b1; i.memtoreg = 1'b1; i.alusrc = 1'b1;
        i.imm = 32'h10; i.rd1 = 32'h1000;
        return i;
    endfunction

    function automatic instr_t add_i(input int rd, input int rs, input int rt);
        instr_t i = '0;
        i.valid = 1'b1; i.rs = AW'(rs); i.rt = AW'(rt); i.rd = AW'(rd);
        i.uses_rt = 1'b1; i.regwrite = 1'b1; i.regdst = 1'b1; i.aluop = 4'd2;
        i.rd1 = 32'h11; i.rd2 = 32'h22;
        return i;
    endfunction

    function automatic instr_t beq_i(input int rs, input int rt);
        instr_t i = '0;
        i.valid = 1'b1; i.rs = AW'(rs); i.rt = AW'(rt);
        i.uses_rt = 1'b1; i.branch = 1'b1; i.aluop = 4'd6; i.imm = 32'hFFFF_FFFC;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        IF_ID_VALID = i.valid; IF_ID_RS = i.rs; IF_ID_RT = i.rt; IF_ID_RD = i.rd;
        ID_USES_RT = i.uses_rt; ID_BRANCH = i.branch; ID_REGWRITE = i.regwrite;
        ID_MEMREAD = i.memread; ID_MEMWRITE = i.memwrite; ID_MEMTOREG = i.memtoreg;
        ID_ALUSRC = i.alusrc; ID_REGDST = i.regdst; ID_ALUOP = i.aluop;
        ID_RD1 = i.rd1; ID_RD2 = i.rd2; ID_IMM = i.imm;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // The model only knows "how many more bubbles are owed" and what the
    // stage register should contain; it recomputes the hazard rules from IF/ID.
    stage_t      m_stage  = '0;
    int          m_extra  = 0;
    bit          m_known  = 1'b0;
    logic [31:0] m_stalls = '0;
    logic [31:0] m_flushes = '0;

    function automatic bit reads_reg(input logic [AW-1:0] r);
        return (r != 0) && ((IF_ID_RS == r) || (ID_USES_RT && (IF_ID_RT == r)));
    endfunction

    function automatic int bubbles_needed(input stage_t s);
        int n = 0;
        if (!IF_ID_VALID) return 0;
        if (s.valid && s.memread && reads_reg(s.wreg)) n = ID_BRANCH ? 2 : 1;
        if (n == 0 && ID_BRANCH &&
            ((s.valid && s.regwrite && !s.memread && reads_reg(s.wreg)) ||
             (EX_MEM_MEMREAD && reads_reg(EX_MEM_RD))))
            n = 1;
        return n;
    endfunction

    always @(negedge clk) begin
        int     need;
        bit     stall_exp;
        bit     pcw_exp;
        stage_t act;
        need      = bubbles_needed(m_stage);
        stall_exp = !GLOBAL_STALL && !FLUSH && ((m_extra > 0) || (need > 0));
        pcw_exp   = !GLOBAL_STALL && !stall_exp;
        act = {ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE,
               ID_EX_MEMTOREG, ID_EX_ALUSRC, ID_EX_ALUOP, ID_EX_RS, ID_EX_RT,
               ID_EX_WREG, ID_EX_RD1, ID_EX_RD2, ID_EX_IMM};
        if (m_known) begin
            check("id_ex_regs", act, m_stage);
            check("haz_stall", HAZ_STALL, stall_exp);
            check("pc_write", PC_WRITE, pcw_exp);
            check("if_id_write", IF_ID_WRITE, pcw_exp);
`ifdef HAZARD_STATS_EN
            check("stall_cycles", STALL_CYCLES, m_stalls);
            check("flush_count", FLUSH_COUNT, m_flushes);
`endif
        end
        if (!rst_n) begin
            m_stage = '0; m_extra = 0; m_stalls = '0; m_flushes = '0; m_known = 1'b1;
        end else if (!GLOBAL_STALL) begin
            if (stall_exp && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (FLUSH) begin
                if (m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
                m_stage = '0; m_extra = 0;
            end else if (m_extra > 0) begin
                m_stage = '0; m_extra = m_extra - 1;
            end else if (need > 0) begin
                m_stage = '0; m_extra = need - 1;
            end else begin
                m_stage.valid = IF_ID_VALID;   m_stage.regwrite = ID_REGWRITE;
                m_stage.memread = ID_MEMREAD;  m_stage.memwrite = ID_MEMWRITE;
                m_stage.memtoreg = ID_MEMTOREG; m_stage.alusrc = ID_ALUSRC;
                m_stage.aluop = ID_ALUOP;      m_stage.rs = IF_ID_RS;
                m_stage.rt = IF_ID_RT;         m_stage.wreg = ID_REGDST ? IF_ID_RD : IF_ID_RT;
                m_stage.rd1 = ID_RD1;          m_stage.rd2 = ID_RD2;
                m_stage.imm = ID_IMM;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; GLOBAL_STALL = 1'b0; FLUSH = 1'b0;
        EX_MEM_MEMREAD = 1'b0; EX_MEM_RD = '0;
        drive(nop_i());
        step(); step();
        rst_n = 1'b1;
        #1;
        check("reset_valid", ID_EX_VALID, 1'b0);
        check("reset_pc_write", PC_WRITE, 1'b1);

        // load-use: lw $8 then add $3,$8,$2
        drive(lw_i(8, 1)); step();
        drive(add_i(3, 8, 2)); #1;
        check("lu_haz", HAZ_STALL, 1'b1);
        check("lu_pcw", PC_WRITE, 1'b0);
        check("lu_wreg", ID_EX_WREG, 5'd8);
        step();
        check("lu_bubble", {ID_EX_VALID, ID_EX_REGWRITE, HAZ_STALL, PC_WRITE}, 4'b0001);
        step(); drive(nop_i()); #1;
        check("lu_capture", {ID_EX_VALID, ID_EX_RS, ID_EX_WREG}, {1'b1, 5'd8, 5'd3});

        // lw $9 then beq $9,$0: two bubbles, capture on third edge
        drive(lw_i(9, 1)); step();
        drive(beq_i(9, 0)); #1;
        check("lb_haz1", {HAZ_STALL, PC_WRITE}, 2'b10);
        step();
        check("lb_haz2", {HAZ_STALL, PC_WRITE, ID_EX_VALID}, 3'b100);
        step();
        check("lb_run", {HAZ_STALL, PC_WRITE, ID_EX_VALID}, 3'b010);
        step(); drive(nop_i()); #1;
        check("lb_capture", {ID_EX_VALID, ID_EX_RS}, {1'b1, 5'd9});
`ifdef HAZARD_STATS_EN
        check("stats_three", STALL_CYCLES, 32'd3);
`endif

        // add $10 then beq $10,$10: one bubble; same with $0: no stall
        drive(add_i(10, 1, 2)); step();
        drive(beq_i(10, 10)); #1;
        check("ba_haz", HAZ_STALL, 1'b1);
        step();
        check("ba_bubble", {HAZ_STALL, ID_EX_VALID}, 2'b00);
        step(); drive(nop_i()); #1;
        check("ba_capture", {ID_EX_VALID, ID_EX_RS}, {1'b1, 5'd10});
        drive(add_i(0, 1, 2)); step();
        drive(beq_i(0, 0)); #1;
        check("zero_nostall", {HAZ_STALL, PC_WRITE}, 2'b01);
        step(); drive(nop_i()); #1;
        check("zero_capture", ID_EX_VALID, 1'b1);

        // FLUSH while in HOLD
        drive(lw_i(9, 1)); step();
        drive(beq_i(9, 0)); step();
        FLUSH = 1'b1; #1;
        check("fl_pcw", {PC_WRITE, HAZ_STALL}, 2'b10);
        step(); FLUSH = 1'b0; drive(nop_i()); #1;
        check("fl_after", {ID_EX_VALID, HAZ_STALL, PC_WRITE}, 3'b001);

        // GLOBAL_STALL for three cycles in the middle of HOLD
        drive(lw_i(9, 1)); step();
        drive(beq_i(9, 0)); step();
        GLOBAL_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gs_frozen", {HAZ_STALL, PC_WRITE, ID_EX_VALID}, 3'b000);
            step();
        end
        GLOBAL_STALL = 1'b0; #1;
        check("gs_resume", {HAZ_STALL, PC_WRITE}, 2'b10);
        step();
        check("gs_run", {HAZ_STALL, PC_WRITE}, 2'b01);
        step(); drive(nop_i()); #1;
        check("gs_capture", {ID_EX_VALID, ID_EX_RS}, {1'b1, 5'd9});

        // reset in the middle of a load-use stall
        drive(lw_i(8, 1)); step();
        drive(add_i(3, 8, 2)); #1;
        check("rs_haz", HAZ_STALL, 1'b1);
        rst_n = 1'b0;
        step(); rst_n = 1'b1; drive(nop_i()); #1;
        check("rs_clear", {ID_EX_VALID, ID_EX_MEMREAD, ID_EX_WREG, PC_WRITE}, {1'b0, 1'b0, 5'd0, 1'b1});

        // random traffic on a small register set to make hazards frequent
        for (int c = 0; c < 3000; c++) begin
            instr_t r;
            r = '0;
            r.valid    = ($urandom_range(0, 7) != 0);
            r.rs       = AW'($urandom_range(0, 3));
            r.rt       = AW'($urandom_range(0, 3));
            r.rd       = AW'($urandom_range(0, 3));
            r.uses_rt  = ($urandom_range(0, 1) != 0);
            r.branch   = ($urandom_range(0, 3) == 0);
            r.regwrite = ($urandom_range(0, 1) != 0);
            r.memread  = ($urandom_range(0, 2) == 0);
            r.memwrite = ($urandom_range(0, 3) == 0);
            r.memtoreg = ($urandom_range(0, 1) != 0);
            r.alusrc   = ($urandom_range(0, 1) != 0);
            r.regdst   = ($urandom_range(0, 1) != 0);
            r.aluop    = OW'($urandom_range(0, 15));
            r.rd1      = $urandom();
            r.rd2      = $urandom();
            r.imm      = $urandom();
            drive(r);
            EX_MEM_MEMREAD = ($urandom_range(0, 3) == 0);
            EX_MEM_RD      = AW'($urandom_range(0, 3));
            FLUSH          = ($urandom_range(0, 15) == 0);
            GLOBAL_STALL   = ($urandom_range(0, 9) == 0);
            rst_n          = ($urandom_range(0, 199) != 0);
            step();
        end

        drive(nop_i()); rst_n = 1'b1; FLUSH = 1'b0; GLOBAL_STALL = 1'b0;
        step(); step();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated stall/bubble control.
- Captures decoded operands, register addresses and control from ID, and presents ID_EX_* to the EX stage and the forwarding unit.
- Detects load-use and branch-in-ID data hazards that forwarding cannot cover. Resolves them by holding PC and IF/ID while injecting bubbles, using a small stall FSM.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register specifier width
- ALUOP_W, 4, ALU op code width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset
- GLOBAL_STALL  in  1  freeze whole pipeline (memory wait)
- FLUSH  in  1  branch taken/mispredict: squash ID instruction
- IF_ID_VALID  in  1  ID holds a real instruction
- IF_ID_RS / IF_ID_RT / IF_ID_RD  in  REG_ADDR_W each  ID specifiers
- ID_USES_RT  in  1  instruction reads RT as a source
- ID_BRANCH  in  1  branch resolved in ID
- ID_REGWRITE, ID_MEMREAD, ID_MEMWRITE, ID_MEMTOREG, ID_ALUSRC, ID_REGDST  in  1 each  decoded control
- ID_ALUOP  in  ALUOP_W  ALU op
- ID_RD1, ID_RD2, ID_IMM  in  DATA_W each  register-file data, sign-extended immediate
- EX_MEM_MEMREAD  in  1  load currently in MEM
- EX_MEM_RD  in  REG_ADDR_W  its destination
- ID_EX_VALID, ID_EX_REGWRITE, ID_EX_MEMREAD, ID_EX_MEMWRITE, ID_EX_MEMTOREG, ID_EX_ALUSRC  out  1 each  registered control
- ID_EX_ALUOP  out  ALUOP_W
- ID_EX_RS, ID_EX_RT  out  REG_ADDR_W  to forwarding unit
- ID_EX_WREG  out  REG_ADDR_W  destination (ID_REGDST ? RD : RT)
- ID_EX_RD1, ID_EX_RD2, ID_EX_IMM  out  DATA_W
- PC_WRITE, IF_ID_WRITE  out  1  combinational hold enables (0 = hold)
- HAZ_STALL  out  1  bubble being injected this cycle

Behaviour:
- Reset: synchronous, active-low; all registered outputs 0, FSM in RUN, counter 0. The reset value is a bubble.
- Bubble definition: VALID, REGWRITE, MEMREAD, MEMWRITE all 0; other fields 0.
- Hazard classes, evaluated in RUN on the current IF/ID and ID/EX contents; "src match" = (IF_ID_RS == R or (ID_USES_RT and IF_ID_RT == R)) with R != 0 and IF_ID_VALID:
- H_LOAD: ID_EX_VALID & ID_EX_MEMREAD & src match on ID_EX_WREG → 1 bubble (2 if ID_BRANCH).
- H_BR_ALU: ID_BRANCH & ID_EX_VALID & ID_EX_REGWRITE & !ID_EX_MEMREAD & src match on ID_EX_WREG → 1 bubble.
- H_BR_MEM: ID_BRANCH & EX_MEM_MEMREAD & src match on EX_MEM_RD → 1 bubble.
- Bubble count = maximum over all matching classes.
- FSM:
  - RUN, hazard with count N: inject bubble, PC_WRITE = IF_ID_WRITE = 0, HAZ_STALL = 1. If N = 2, go to HOLD with counter = 1; otherwise stay in RUN. Hazards are re-evaluated next cycle.
  - HOLD: inject bubble, hold IF/ID, decrement counter, return to RUN when counter reaches 0.
  - Max latency added: 2 cycles.
- Priority, per cycle: rst_n low > GLOBAL_STALL (all registers and FSM hold; PC_WRITE = IF_ID_WRITE = 0; HAZ_STALL = 0) > FLUSH (load bubble, FSM → RUN, counter 0, PC_WRITE = IF_ID_WRITE = 1) > hazard bubble > normal capture.
- Normal capture: all ID_* fields registered on the clock edge; ID_EX_VALID = IF_ID_VALID.
- Invalid ID instruction never raises a hazard.
- Combinational outputs (PC_WRITE, IF_ID_WRITE, HAZ_STALL) depend only on current state and inputs, with no loops through clk.

Optional Feature:
- HAZARD_STATS_EN defined: adds outputs STALL_CYCLES and FLUSH_COUNT (32-bit each, in that order).
  - Saturating counters, reset to 0.
  - STALL_CYCLES increments each HAZ_STALL cycle; FLUSH_COUNT increments each FLUSH cycle not blocked by GLOBAL_STALL.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared include/package mips_pipe_defs:
  - FSM state encodings ST_RUN = 1'b0, ST_HOLD = 1'b1
  - ALUOP_W and REG_ADDR_W constants
  - bubble control constant
- Sub-module hazard_classifier: combinational; emits bubble count (0..2) from the specifier, valid and control inputs.
- The FSM and registers stay in id_ex_stage_reg.

Test Plan:
- lw $8 in ID/EX, add using $8 in ID → one cycle HAZ_STALL = 1, PC_WRITE = 0, ID/EX holds bubble. Next cycle add captured with ID_EX_RS = 8.
- lw $9 in ID/EX, beq $9,$0 in ID → two consecutive bubble cycles (FSM RUN→HOLD→RUN); beq captured on the 3rd edge.
- add $10 in ID/EX, beq $10,$10 in ID → one bubble. The same sequence with $0 as destination → no stall.
- FLUSH = 1 while in HOLD → bubble loaded, FSM returns to RUN, PC_WRITE = 1 that cycle.
- GLOBAL_STALL = 1 for 3 cycles mid-HOLD → all outputs frozen, counter unchanged; the remaining bubble is injected after release.
- rst_n = 0 asserted during a stall → next edge: all ID_EX_* = 0, RUN, PC_WRITE = 1.
- With HAZARD_STATS_EN: STALL_CYCLES = 3 after the 1-bubble and 2-bubble scenarios back-to-back.
